regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised multi-port integer register file with clocked writes, optional same-cycle write-to-read bypass and a per-register busy scoreboard.
- Successor to the single-write, two-read combinational register file in the CPU datapath.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).
- Register 0 is hardwired to zero.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NR, 2, number of read ports.
- NW, 1, number of write ports (1..2).
- BYPASS, 1, 1 = a read of an address written this cycle returns the write data combinationally; 0 = old value until next cycle.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  NW  per-port write enable.
- wr_addr  input  NW*AW  write addresses, port k at bits [k*AW +: AW].
- wr_data  input  NW*DW  write data, port k at bits [k*DW +: DW].
- rd_addr  input  NR*AW  read addresses, packed the same way.
- rd_data  output  NR*DW  read data, combinational.
- rd_busy  output  NR  scoreboard busy bit of each read address, combinational.
- sb_set_en  input  1  mark sb_set_addr busy (instruction issued with destination).
- sb_set_addr  input  AW  destination register to mark busy.

Behaviour:
- Storage: 2**AW x DW flops.
  - Register 0 is never written; it always reads 0 and is never busy.
- Reset (rst=1 at posedge): all registers cleared to 0 and all busy bits cleared. Reset overrides any write or sb_set in the same cycle.
- Write: at posedge, for each k with wr_en[k]=1 and wr_addr[k]!=0, reg[wr_addr[k]] <= wr_data[k].
  - Write conflict (NW=2, same nonzero address, both enabled): port 1 wins.
- Read: rd_data[j] = 0 if rd_addr[j]==0; otherwise the bypass value if applicable; otherwise reg[rd_addr[j]].
  - Bypass (BYPASS=1): if any enabled write port targets rd_addr[j]!=0 this cycle, return that write data (highest port index on conflict).
  - BYPASS=0: written value appears on rd_data one cycle after the write edge.
- Scoreboard: one busy bit per register; bit 0 is tied to 0.
  - Clear: at posedge, an enabled write to address a clears busy[a].
  - Set: at posedge, sb_set_en with sb_set_addr=a sets busy[a]. Set to address 0 is ignored.
  - Simultaneous set and clear of the same address: set wins (a new producer is in flight), so busy stays 1.
  - rd_busy[j] = busy[rd_addr[j]], with bypass semantics when BYPASS=1: a write clearing rd_addr[j] this cycle forces rd_busy[j]=0 unless sb_set_en targets the same address.
- No internal state machine beyond storage and scoreboard; all outputs are combinational from state and inputs.
- Output values during reset cycle: reflect pre-reset state plus bypass; after the reset edge all rd_data=0 and rd_busy=0.
- Latency: write-to-read 0 cycles (BYPASS=1) or 1 cycle (BYPASS=0). Set-to-busy 1 cycle.

Optional Feature:
REGFILE_DEBUG_EN
- Defined: adds ports dbg_addr (input, AW), dbg_data (output, DW), dbg_busy (output, 1) and wr_count (output, 32).
  - dbg_data and dbg_busy give the raw stored value and busy bit, without bypass; address 0 returns 0/0.
  - wr_count increments once per posedge for each enabled write to a nonzero address (+2 for a dual write). It is cleared by rst and wraps at 2**32.
- Undefined: these ports and the counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then read: rst high one cycle, then read all addresses -> every rd_data=0 and rd_busy=0.
- Write/read, BYPASS=1: write 0xDEADBEEF to r5 and read r5 in the same cycle -> rd_data=0xDEADBEEF that cycle; still 0xDEADBEEF after the edge.
- Write/read, BYPASS=0: same stimulus -> rd_data=0 that cycle, 0xDEADBEEF next cycle.
- Zero register: write 0x12345678 to r0 with sb_set to r0 -> rd_data(r0)=0 and rd_busy=0 forever.
- Scoreboard: sb_set r7 at cycle 1 -> rd_busy(r7)=1 from cycle 2. Write r7 plus sb_set r7 at cycle 4 -> busy stays 1. Write r7 alone at cycle 6 -> busy=0 after the edge (same cycle with BYPASS=1).
- Dual-port conflict (NW=2): both ports write r3, port0=0x1 and port1=0x2 -> r3=0x2. Assert rst during a write to r9 -> r9=0 after the edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register busy scoreboard and an optional write-to-read bypass.
// Define REGFILE_DEBUG_EN to add raw debug read ports and a write counter.
module regfile_mp_sb #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    wr_en,
  input  logic [NW*AW-1:0] wr_addr,
  input  logic [NW*DW-1:0] wr_data,
  input  logic [NR*AW-1:0] rd_addr,
  input  logic             sb_set_en,
  input  logic [AW-1:0]    sb_set_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_busy
`ifdef REGFILE_DEBUG_EN
  ,
  input  logic [AW-1:0]    dbg_addr,
  output logic [DW-1:0]    dbg_data,
  output logic             dbg_busy,
  output logic [31:0]      wr_count
`endif
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    r_regs [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Scoreboard next state: writes clear, the issue-side set is applied last so it wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k]) w_busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (sb_set_en) w_busy_nxt[sb_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Storage: ports are visited in ascending order so the highest port wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
          r_regs[wr_addr[k*AW +: AW]] <= wr_data[k*DW +: DW];
      end
      r_busy <= w_busy_nxt;
    end
  end

  logic [AW-1:0] w_ra;
  logic [DW-1:0] w_rd;
  logic          w_rb;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    w_rd    = '0;
    w_rb    = 1'b0;
    for (int j = 0; j < NR; j++) begin
      w_ra = rd_addr[j*AW +: AW];
      w_rd = r_regs[w_ra];
      w_rb = r_busy[w_ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < NW; k++) begin
          if (wr_en[k] && (wr_addr[k*AW +: AW] == w_ra)) begin
            w_rd = wr_data[k*DW +: DW];
            // A same-cycle re-issue to this register keeps it busy.
            if (!(sb_set_en && (sb_set_addr == w_ra))) w_rb = 1'b0;
          end
        end
      end
      if (w_ra == '0) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
      rd_data[j*DW +: DW] = w_rd;
      rd_busy[j]          = w_rb;
    end
  end

`ifdef REGFILE_DEBUG_EN
  logic [31:0] w_wr_inc;
  logic [31:0] r_wr_count;

  always_comb begin
    w_wr_inc = '0;
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] != '0)) w_wr_inc = w_wr_inc + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_wr_count <= '0;
    else     r_wr_count <= r_wr_count + w_wr_inc;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
  assign dbg_busy = r_busy[dbg_addr];
  assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: a dual-write bypassing instance and a single-write
// non-bypassing instance share stimulus (the second sees write port 0 only).
`timescale 1ns/1ps
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*AW-1:0] rd_addr;
  logic          sb_set_en;
  logic [AW-1:0] sb_set_addr;
  logic [2*DW-1:0] a_rd_data, b_rd_data;
  logic [1:0]    a_rd_busy, b_rd_busy;
  logic [0:0]    b_wr_en;
  logic [AW-1:0] b_wr_addr;
  logic [DW-1:0] b_wr_data;

  assign b_wr_en   = wr_en[0:0];
  assign b_wr_addr = wr_addr[AW-1:0];
  assign b_wr_data = wr_data[DW-1:0];

`ifdef REGFILE_DEBUG_EN
  logic [AW-1:0] a_dbg_addr, b_dbg_addr;
  logic [DW-1:0] a_dbg_data, b_dbg_data;
  logic          a_dbg_busy, b_dbg_busy;
  logic [31:0]   a_wr_count, b_wr_count;
  assign a_dbg_addr = rd_addr[AW-1:0];
  assign b_dbg_addr = rd_addr[AW-1:0];
`endif

  regfile_mp_sb #(.DW(DW), .AW(AW), .NR(2), .NW(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy)
`ifdef REGFILE_DEBUG_EN
    , .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data), .dbg_busy(a_dbg_busy), .wr_count(a_wr_count)
`endif
  );

  regfile_mp_sb #(.DW(DW), .AW(AW), .NR(2), .NW(1), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_addr(rd_addr), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy)
`ifdef REGFILE_DEBUG_EN
    , .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data), .dbg_busy(b_dbg_busy), .wr_count(b_wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, chk;
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic [4:0]  ra0, ra1;
    logic        se;  logic [4:0] sa;
    logic [31:0] ad0, ad1; logic [1:0] ab;   // ab = {port1, port0}
    logic [31:0] bd0, bd1; logic [1:0] bb;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    logic r, logic c, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
    logic [4:0] wa1, logic [31:0] wd1, logic [4:0] ra0, logic [4:0] ra1,
    logic se, logic [4:0] sa, logic [31:0] ad0, logic [31:0] ad1, logic [1:0] ab,
    logic [31:0] bd0, logic [31:0] bd1, logic [1:0] bb);
    vec_t v;
    v.rst = r; v.chk = c; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ra0 = ra0; v.ra1 = ra1; v.se = se; v.sa = sa;
    v.ad0 = ad0; v.ad1 = ad1; v.ab = ab; v.bd0 = bd0; v.bd1 = bd1; v.bb = bb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [31:0] ad0, input logic [31:0] ad1, input logic [1:0] ab,
                           input logic [31:0] bd0, input logic [31:0] bd1, input logic [1:0] bb);
    check({tag, " a.rd0"}, a_rd_data[31:0],  ad0);
    check({tag, " a.rd1"}, a_rd_data[63:32], ad1);
    check({tag, " a.busy"}, {30'd0, a_rd_busy}, {30'd0, ab});
    check({tag, " b.rd0"}, b_rd_data[31:0],  bd0);
    check({tag, " b.rd1"}, b_rd_data[63:32], bd1);
    check({tag, " b.busy"}, {30'd0, b_rd_busy}, {30'd0, bb});
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 2'b00; wr_addr = '0; wr_data = '0; sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  initial begin
    //        rst chk we     wa0 wd0           wa1 wd1    ra0 ra1 se sa   ad0           ad1           ab     bd0           bd1           bb
    tbl[0]  = mk(1, 0, 2'b00, 0,  0,            0,  0,     0,  0,  0, 0,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[1]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     0,  5,  0, 0,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[2]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     31, 17, 0, 0,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[3]  = mk(0, 1, 2'b01, 5,  32'hDEADBEEF, 0,  0,     5,  0,  0, 0,  32'hDEADBEEF, 0,            2'b00, 0,            0,            2'b00);
    tbl[4]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     5,  5,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    tbl[5]  = mk(0, 1, 2'b01, 0,  32'h12345678, 0,  0,     0,  0,  1, 0,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[6]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     0,  5,  0, 0,  0,            32'hDEADBEEF, 2'b00, 0,            32'hDEADBEEF, 2'b00);
    tbl[7]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     7,  7,  1, 7,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[8]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     7,  7,  0, 0,  0,            0,            2'b11, 0,            0,            2'b11);
    tbl[9]  = mk(0, 1, 2'b00, 0,  0,            0,  0,     7,  0,  0, 0,  0,            0,            2'b01, 0,            0,            2'b01);
    tbl[10] = mk(0, 1, 2'b01, 7,  32'h0000A5A5, 0,  0,     7,  5,  1, 7,  32'h0000A5A5, 32'hDEADBEEF, 2'b01, 0,            32'hDEADBEEF, 2'b01);
    tbl[11] = mk(0, 1, 2'b00, 0,  0,            0,  0,     7,  5,  0, 0,  32'h0000A5A5, 32'hDEADBEEF, 2'b01, 32'h0000A5A5, 32'hDEADBEEF, 2'b01);
    tbl[12] = mk(0, 1, 2'b01, 7,  32'h00005A5A, 0,  0,     7,  7,  0, 0,  32'h00005A5A, 32'h00005A5A, 2'b00, 32'h0000A5A5, 32'h0000A5A5, 2'b11);
    tbl[13] = mk(0, 1, 2'b00, 0,  0,            0,  0,     7,  7,  0, 0,  32'h00005A5A, 32'h00005A5A, 2'b00, 32'h00005A5A, 32'h00005A5A, 2'b00);
    tbl[14] = mk(0, 1, 2'b11, 3,  32'h1,        3,  32'h2, 3,  3,  0, 0,  32'h2,        32'h2,        2'b00, 0,            0,            2'b00);
    tbl[15] = mk(0, 1, 2'b00, 0,  0,            0,  0,     3,  0,  0, 0,  32'h2,        0,            2'b00, 32'h1,        0,            2'b00);
    tbl[16] = mk(0, 1, 2'b11, 10, 32'h10,       11, 32'h11,10, 11, 0, 0,  32'h10,       32'h11,       2'b00, 0,            0,            2'b00);
    tbl[17] = mk(0, 1, 2'b00, 0,  0,            0,  0,     10, 11, 1, 12, 32'h10,       32'h11,       2'b00, 32'h10,       0,            2'b00);
    tbl[18] = mk(1, 1, 2'b01, 9,  32'h99,       0,  0,     9,  3,  1, 9,  32'h99,       32'h2,        2'b00, 0,            32'h1,        2'b00);
    tbl[19] = mk(0, 1, 2'b00, 0,  0,            0,  0,     9,  3,  0, 0,  0,            0,            2'b00, 0,            0,            2'b00);
    tbl[20] = mk(0, 1, 2'b00, 0,  0,            0,  0,     12, 10, 0, 0,  0,            0,            2'b00, 0,            0,            2'b00);

    idle();
    rd_addr = '0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst         = tbl[i].rst;
      wr_en       = tbl[i].we;
      wr_addr     = {tbl[i].wa1, tbl[i].wa0};
      wr_data     = {tbl[i].wd1, tbl[i].wd0};
      rd_addr     = {tbl[i].ra1, tbl[i].ra0};
      sb_set_en   = tbl[i].se;
      sb_set_addr = tbl[i].sa;
      #1;
      if (tbl[i].chk)
        check_all($sformatf("vec%0d", i), tbl[i].ad0, tbl[i].ad1, tbl[i].ab,
                  tbl[i].bd0, tbl[i].bd1, tbl[i].bb);
    end

    // Port-1-only write clearing a busy register: bypassed on A, absent on B.
    @(negedge clk);
    idle();
    sb_set_en = 1'b1; sb_set_addr = 5'd20; rd_addr = {5'd20, 5'd20};
    #1 check_all("seq_set", 0, 0, 2'b00, 0, 0, 2'b00);
    @(negedge clk);
    idle();
    wr_en = 2'b10; wr_addr = {5'd20, 5'd0}; wr_data = {32'h77, 32'h0};
    #1 check_all("seq_clr", 32'h77, 32'h77, 2'b00, 0, 0, 2'b11);
    @(negedge clk);
    idle();
    #1 check_all("seq_after", 32'h77, 32'h77, 2'b00, 0, 0, 2'b11);

    // Full reset, then sweep every address on both read ports.
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    idle();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = {a[4:0], a[4:0]};
      #1 check_all($sformatf("sweep%0d", a), 0, 0, 2'b00, 0, 0, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
